// File: rtl/can_tx_pkg.sv
// Shared types and helpers for the CAN transmit arbiter.
// FSM state encoding, arbitration mode codes and frame ID extraction.
package can_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREPARE,
        LATCH,
        SEND,
        WAIT_DONE
    } state_t;

    localparam int MODE_FIXED  = 0;
    localparam int MODE_LOW_ID = 1;

    localparam int MAX_DATA_W = 1024;
    localparam int MAX_ID_W   = 32;

    // ID sits in the top id_w bits of a data_w-wide frame.
    function automatic logic [MAX_ID_W-1:0] frame_id(
        input logic [MAX_DATA_W-1:0] frame,
        input int                    data_w,
        input int                    id_w
    );
        logic [MAX_ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < MAX_ID_W; i++) begin
            if (i < id_w) begin
                id[i] = frame[data_w - id_w + i];
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/can_tx_prio_sel.sv
// Combinational winner select across all transmit sources.
// Fixed-index or lowest-ID priority; ID ties go to the lower index.
module can_tx_prio_sel
    import can_tx_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 128,
    parameter int ID_W   = 11,
    parameter int MODE   = 0,
    parameter int SEL_W  = 2
) (
    input  logic [N_SRC-1:0]        valid,
    input  logic [N_SRC*DATA_W-1:0] data,
    output logic                    any,
    output logic [SEL_W-1:0]        win
);

    logic [ID_W-1:0] best_id;
    logic [ID_W-1:0] cur_id;

    always_comb begin
        any     = 1'b0;
        win     = '0;
        best_id = '1;
        cur_id  = '0;
        for (int s = 0; s < N_SRC; s++) begin
            cur_id = ID_W'(frame_id(
                MAX_DATA_W'(data[s*DATA_W +: DATA_W]), DATA_W, ID_W));
            if (valid[s]) begin
                // Strict compare keeps the first (lowest) index on equal IDs.
                if (!any || (MODE == MODE_LOW_ID && cur_id < best_id)) begin
                    any     = 1'b1;
                    win     = SEL_W'(s);
                    best_id = cur_id;
                end
            end
        end
    end

endmodule

// File: rtl/can_tx_arbiter.sv
// Arbitrates N transmit sources onto one CAN core, with retry on
// arbitration loss, abort, and a synchronized core-busy handshake.
module can_tx_arbiter
    import can_tx_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 11,
    parameter int MODE      = 0,
    parameter int MAX_RETRY = 8
) (
    input  logic                    i_sys_clk,
    input  logic                    i_reset_n,
    input  logic                    i_cen,
    input  logic [N_SRC-1:0]        i_src_valid,
    input  logic [N_SRC*DATA_W-1:0] i_src_data,
    output logic [N_SRC-1:0]        o_src_r_en,
    input  logic                    i_busy_can,
    input  logic                    i_tx_done,
    input  logic                    i_arb_lost,
    input  logic                    i_abort,
    output logic [DATA_W-1:0]       o_send_data,
    output logic                    o_send_en,
    output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] o_src_sel,
    output logic                    o_tx_ok,
    output logic                    o_tx_fail
);

    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);

    state_t            state;
    state_t            state_n;
    logic              busy_m;
    logic              busy_s;
    logic [1:0]        warm;
    logic [7:0]        retry;
    logic [DATA_W-1:0] latch_data;
    logic              any_valid;
    logic [SEL_W-1:0]  win;
    logic              do_pop;
    logic              do_ok;
    logic              do_fail;
    logic              do_retry;

    can_tx_prio_sel #(
        .N_SRC  (N_SRC),
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .MODE   (MODE),
        .SEL_W  (SEL_W)
    ) u_sel (
        .valid (i_src_valid),
        .data  (i_src_data),
        .any   (any_valid),
        .win   (win)
    );

    // Warm-up counter holds IDLE until the busy synchronizer has filled.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
            warm   <= 2'd0;
        end else begin
            busy_m <= i_busy_can;
            busy_s <= busy_m;
            if (!warm[1]) begin
                warm <= warm + 2'd1;
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        do_pop   = 1'b0;
        do_ok    = 1'b0;
        do_fail  = 1'b0;
        do_retry = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_cen && !busy_s && warm[1]) begin
                    state_n = PREPARE;
                end
            end
            PREPARE: begin
                if (!i_cen) begin
                    state_n = IDLE;
                end else if (any_valid) begin
                    state_n = LATCH;
                    do_pop  = 1'b1;
                end
            end
            LATCH: begin
                state_n = SEND;
            end
            SEND: begin
                if (i_abort) begin
                    do_fail = 1'b1;
                    state_n = PREPARE;
                end else if (busy_s) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    do_ok   = 1'b1;
                    state_n = PREPARE;
                end else if (i_abort) begin
                    do_fail = 1'b1;
                    state_n = PREPARE;
                end else if (i_arb_lost) begin
                    if (retry < RETRY_LAST) begin
                        do_retry = 1'b1;
                        state_n  = SEND;
                    end else begin
                        do_fail = 1'b1;
                        state_n = PREPARE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            latch_data <= '0;
            o_src_sel  <= '0;
            o_src_r_en <= '0;
            o_tx_ok    <= 1'b0;
            o_tx_fail  <= 1'b0;
            retry      <= 8'd0;
        end else begin
            o_src_r_en <= '0;
            o_tx_ok    <= do_ok;
            o_tx_fail  <= do_fail;
            if (do_pop) begin
                latch_data <= i_src_data[int'(win)*DATA_W +: DATA_W];
                o_src_sel  <= win;
                o_src_r_en <= N_SRC'(1) << win;
                retry      <= 8'd0;
            end else if (do_retry) begin
                retry <= retry + 8'd1;
            end
        end
    end

    assign o_send_en   = (state == SEND);
    assign o_send_data = latch_data;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected pops and status pulses,
// a negedge monitor compares them as the arbiters present outputs.
module tb_can_tx_arbiter;
    import can_tx_pkg::*;

    localparam int N  = 4;
    localparam int DW = 128;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            cen      = 1'b0;
    logic            busy     = 1'b0;
    logic            tx_done  = 1'b0;
    logic            arb_lost = 1'b0;
    logic            abort    = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    m1_valid  = '0;
    logic [N*DW-1:0] src_data  = '0;

    logic [N-1:0]  r_en;
    logic [DW-1:0] send_data;
    logic          send_en;
    logic [1:0]    sel;
    logic          ok;
    logic          fail;

    logic [N-1:0]  m1_r_en;
    logic [DW-1:0] m1_send_data;
    logic          m1_send_en;
    logic [1:0]    m1_sel;
    logic          m1_ok;
    logic          m1_fail;

    always #5 clk = ~clk;

    can_tx_arbiter #(
        .N_SRC(N), .DATA_W(DW), .ID_W(11), .MODE(0), .MAX_RETRY(3)
    ) u_dut (
        .i_sys_clk   (clk),
        .i_reset_n   (rst_n),
        .i_cen       (cen),
        .i_src_valid (src_valid),
        .i_src_data  (src_data),
        .o_src_r_en  (r_en),
        .i_busy_can  (busy),
        .i_tx_done   (tx_done),
        .i_arb_lost  (arb_lost),
        .i_abort     (abort),
        .o_send_data (send_data),
        .o_send_en   (send_en),
        .o_src_sel   (sel),
        .o_tx_ok     (ok),
        .o_tx_fail   (fail)
    );

    can_tx_arbiter #(
        .N_SRC(N), .DATA_W(DW), .ID_W(11), .MODE(1), .MAX_RETRY(8)
    ) u_dut_m1 (
        .i_sys_clk   (clk),
        .i_reset_n   (rst_n),
        .i_cen       (cen),
        .i_src_valid (m1_valid),
        .i_src_data  (src_data),
        .o_src_r_en  (m1_r_en),
        .i_busy_can  (busy),
        .i_tx_done   (tx_done),
        .i_arb_lost  (arb_lost),
        .i_abort     (abort),
        .o_send_data (m1_send_data),
        .o_send_en   (m1_send_en),
        .o_src_sel   (m1_sel),
        .o_tx_ok     (m1_ok),
        .o_tx_fail   (m1_fail)
    );

    function automatic logic [DW-1:0] frame_of(input int s);
        logic [10:0] id;
        case (s)
            0:       id = 11'h7FF;
            1:       id = 11'h010;
            2:       id = 11'h010;
            default: id = 11'h123;
        endcase
        return {id, 117'(32'hC0DE_0000 + s)};
    endfunction

    int           exp_pop[$];
    int           m1_exp_pop[$];
    logic [1:0]   exp_stat[$];
    logic [1:0]   m1_exp_stat[$];
    string        q_name[$];
    logic [127:0] q_act[$];
    logic [127:0] q_exp[$];

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_rise = 0;
    int   n_pops = 0;
    logic prev_send = 1'b0;
    int   ms;
    logic [1:0] mst;

    task automatic cmp(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    // Monitor: sole owner of the counters.
    always @(negedge clk) begin
        while (q_name.size() > 0) begin
            cmp(q_name.pop_front(), q_act.pop_front(), q_exp.pop_front());
        end
        if (send_en && !prev_send) n_rise++;
        prev_send = send_en;
        if (r_en != '0) begin
            n_pops++;
            if (exp_pop.size() == 0) begin
                cmp("pop_unexpected", 128'(r_en), 128'(0));
            end else begin
                ms = exp_pop.pop_front();
                cmp("pop_ren", 128'(r_en), 128'(4'(1) << ms));
                cmp("pop_sel", 128'(sel), 128'(ms));
                cmp("pop_data", 128'(send_data), 128'(frame_of(ms)));
            end
        end
        if (ok || fail) begin
            mst = (exp_stat.size() == 0) ? 2'b00 : exp_stat.pop_front();
            cmp("status", 128'({ok, fail}), 128'(mst));
        end
        if (m1_r_en != '0) begin
            if (m1_exp_pop.size() == 0) begin
                cmp("m1_pop_unexpected", 128'(m1_r_en), 128'(0));
            end else begin
                ms = m1_exp_pop.pop_front();
                cmp("m1_pop_ren", 128'(m1_r_en), 128'(4'(1) << ms));
                cmp("m1_pop_sel", 128'(m1_sel), 128'(ms));
                cmp("m1_pop_data", 128'(m1_send_data), 128'(frame_of(ms)));
            end
        end
        if (m1_ok || m1_fail) begin
            mst = (m1_exp_stat.size() == 0) ? 2'b00 : m1_exp_stat.pop_front();
            cmp("m1_status", 128'({m1_ok, m1_fail}), 128'(mst));
        end
    end

    task automatic push_chk(input string nm, input logic [127:0] a,
                            input logic [127:0] e);
        q_name.push_back(nm);
        q_act.push_back(a);
        q_exp.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        src_valid = src_valid & ~r_en;
        m1_valid  = m1_valid & ~m1_r_en;
    endtask

    function automatic logic get_send(input int w);
        return (w == 0) ? send_en : m1_send_en;
    endfunction

    task automatic wait_pop();
        int n = 0;
        while (r_en == '0 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) push_chk("wait_pop", 128'(r_en), 128'(1));
    endtask

    task automatic wait_send(input int w);
        int n = 0;
        while (!get_send(w) && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) push_chk("wait_send", 128'(get_send(w)), 128'(1));
    endtask

    task automatic wait_nosend(input int w);
        int n = 0;
        while (get_send(w) && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) push_chk("wait_nosend", 128'(get_send(w)), 128'(0));
    endtask

    // 0 done, 1 arb lost, 2 abort, 3 done+arb lost
    task automatic pulse(input int k);
        tx_done  = (k == 0 || k == 3);
        arb_lost = (k == 1 || k == 3);
        abort    = (k == 2);
        tick();
        tx_done  = 1'b0;
        arb_lost = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic finish_msg(input int w, input logic [1:0] st,
                              input int k);
        wait_send(w);
        busy = 1'b1;
        wait_nosend(w);
        if (w == 0) exp_stat.push_back(st);
        else        m1_exp_stat.push_back(st);
        pulse(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_r;
        int base_p;
        int c;
        for (int s = 0; s < N; s++) src_data[s*DW +: DW] = frame_of(s);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        push_chk("rst0_send_en", 128'(send_en), 128'(0));
        push_chk("rst0_r_en", 128'(r_en), 128'(0));
        push_chk("rst0_sel", 128'(sel), 128'(0));
        push_chk("rst0_data", 128'(send_data), 128'(0));
        push_chk("rst0_stat", 128'({ok, fail}), 128'(0));
        tick();

        // Fixed priority: 0110 -> source 1 then source 2
        exp_pop.push_back(1);
        exp_pop.push_back(2);
        src_valid = 4'b0110;
        cen   = 1'b1;
        rst_n = 1'b1;
        wait_pop();
        tick();
        push_chk("send_en_after_latch", 128'(send_en), 128'(1));
        busy = 1'b1;
        wait_nosend(0);
        exp_stat.push_back(2'b10);
        pulse(0);
        finish_msg(0, 2'b10, 0);
        busy = 1'b0;
        repeat (4) tick();

        // Retry limit 3: three losses -> one fail, one pop
        base_r = n_rise;
        base_p = n_pops;
        exp_pop.push_back(3);
        src_valid = 4'b1000;
        wait_send(0);
        busy = 1'b1;
        wait_nosend(0);
        pulse(1);
        tick();
        pulse(1);
        tick();
        exp_stat.push_back(2'b01);
        pulse(1);
        repeat (2) tick();
        push_chk("retry_rises", 128'(n_rise - base_r), 128'(3));
        push_chk("retry_pops", 128'(n_pops - base_p), 128'(1));
        busy = 1'b0;
        repeat (4) tick();

        // tx_done with arb_lost together -> ok, straight to PREPARE
        exp_pop.push_back(0);
        exp_pop.push_back(1);
        src_valid = 4'b0011;
        wait_send(0);
        busy = 1'b1;
        wait_nosend(0);
        exp_stat.push_back(2'b10);
        pulse(3);
        tick();
        push_chk("done_wins_pop", 128'(r_en), 128'(4'b0010));
        finish_msg(0, 2'b10, 0);
        busy = 1'b0;
        repeat (4) tick();

        // Abort in WAIT_DONE -> fail, send_en low, next source popped
        exp_pop.push_back(0);
        exp_pop.push_back(2);
        src_valid = 4'b0101;
        wait_send(0);
        busy = 1'b1;
        wait_nosend(0);
        exp_stat.push_back(2'b01);
        pulse(2);
        push_chk("abort_send_off", 128'(send_en), 128'(0));
        tick();
        push_chk("abort_next_pop", 128'(r_en), 128'(4'b0100));
        finish_msg(0, 2'b10, 0);
        busy = 1'b0;
        repeat (4) tick();

        // Controller disabled holds sources; abort from SEND; idle abort
        cen = 1'b0;
        repeat (2) tick();
        src_valid = 4'b1000;
        repeat (6) tick();
        push_chk("cen_off_no_pop", 128'(src_valid), 128'(4'b1000));
        exp_pop.push_back(3);
        cen = 1'b1;
        wait_send(0);
        repeat (2) tick();
        push_chk("send_holds_no_busy", 128'(send_en), 128'(1));
        exp_stat.push_back(2'b01);
        pulse(2);
        tick();
        pulse(2);
        repeat (3) tick();

        // Lowest-ID mode: IDs 7FF/010/010/123 -> order 1,2,3,0
        m1_exp_pop.push_back(1);
        m1_exp_pop.push_back(2);
        m1_exp_pop.push_back(3);
        m1_exp_pop.push_back(0);
        m1_valid = 4'b1111;
        for (int i = 0; i < 4; i++) finish_msg(1, 2'b10, 0);
        busy = 1'b0;
        repeat (4) tick();

        // Reset during SEND drops the message silently
        exp_pop.push_back(0);
        src_valid = 4'b0001;
        wait_send(0);
        rst_n = 1'b0;
        #1;
        push_chk("rst_send_en", 128'(send_en), 128'(0));
        push_chk("rst_r_en", 128'(r_en), 128'(0));
        push_chk("rst_sel", 128'(sel), 128'(0));
        push_chk("rst_data", 128'(send_data), 128'(0));
        push_chk("rst_stat", 128'({ok, fail}), 128'(0));
        push_chk("rst_state", 128'(u_dut.state), 128'(IDLE));
        tick();
        exp_pop.push_back(1);
        src_valid = 4'b0010;
        rst_n = 1'b1;
        c = 0;
        while (r_en == '0 && c < 20) begin
            tick();
            c++;
        end
        push_chk("rst_warmup", 128'(c >= 4 && c < 20), 128'(1));
        wait_send(0);
        exp_stat.push_back(2'b01);
        pulse(2);
        repeat (3) tick();

        push_chk("left_pop", 128'(exp_pop.size()), 128'(0));
        push_chk("left_stat", 128'(exp_stat.size()), 128'(0));
        push_chk("left_m1_pop", 128'(m1_exp_pop.size()), 128'(0));
        push_chk("left_m1_stat", 128'(m1_exp_stat.size()), 128'(0));
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/can_tx_arbiter.md
CAN_TX_ARBITER -- requirements
Module: can_tx_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, number of transmit sources; source 0 is the high-priority buffer.
REQ-002 Parameter DATA_W, default 128, message frame width.
REQ-003 Parameter ID_W, default 11, CAN identifier width; the ID occupies frame bits [DATA_W-1 : DATA_W-ID_W].
REQ-004 Parameter MODE, default 0: 0 = fixed index priority, 1 = lowest-ID priority.
REQ-005 Parameter MAX_RETRY, default 8, arbitration-loss retries before a message is dropped; range 1..255.
REQ-006 i_sys_clk  in  1  sole clock; all state and outputs update on its rising edge.
REQ-007 i_reset_n  in  1  asynchronous, active-low reset.
REQ-008 i_cen  in  1  controller enable.
REQ-009 i_src_valid  in  N_SRC  source s holds a message.
REQ-010 i_src_data  in  N_SRC*DATA_W  source s frame in slice [s*DATA_W +: DATA_W].
REQ-011 o_src_r_en  out  N_SRC  one-cycle pop strobe to source s.
REQ-012 i_busy_can  in  1  CAN core busy; asynchronous to i_sys_clk.
REQ-013 i_tx_done  in  1  one-cycle pulse: frame transmitted successfully.
REQ-014 i_arb_lost  in  1  one-cycle pulse: bus arbitration lost.
REQ-015 i_abort  in  1  cancel the pending or retrying message.
REQ-016 o_send_data  out  DATA_W  latched frame presented to the CAN core.
REQ-017 o_send_en  out  1  frame request to the CAN core.
REQ-018 o_src_sel  out  max(1,$clog2(N_SRC))  index of the source owning the latched frame.
REQ-019 o_tx_ok, o_tx_fail  out  1 each  one-cycle completion status pulses.

Function
REQ-020 i_busy_can SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized value (busy_s).
REQ-021 FSM states SHALL be exactly IDLE, PREPARE, LATCH, SEND and WAIT_DONE.
REQ-022 IDLE -> PREPARE when i_cen=1 and busy_s=0.
REQ-023 PREPARE -> LATCH when any i_src_valid is set; the winner is the lowest set index (MODE 0) or the lowest ID, ties to the lowest index (MODE 1).
REQ-024 On entry to LATCH: winner frame into latch_data, winner index into o_src_sel, o_src_r_en[winner]=1 for exactly that one cycle, retry count=0.
REQ-025 LATCH -> SEND after one cycle.
REQ-026 In SEND: o_send_en=1 and o_send_data=latch_data; SEND -> WAIT_DONE once busy_s=1.
REQ-027 In WAIT_DONE: i_tx_done -> o_tx_ok pulse, then PREPARE.
REQ-028 In WAIT_DONE: i_arb_lost with retry count<MAX_RETRY-1 -> increment count, return to SEND with the same latch_data and no pop.
REQ-029 In WAIT_DONE: i_arb_lost with retry count=MAX_RETRY-1 -> o_tx_fail pulse, then PREPARE.
REQ-030 If i_tx_done and i_arb_lost arrive together, i_tx_done SHALL win.
REQ-031 i_abort in SEND or WAIT_DONE -> o_tx_fail pulse, o_send_en=0 the next cycle, then PREPARE; i_abort SHALL be ignored in IDLE, PREPARE and LATCH.
REQ-032 i_cen=0 in PREPARE -> IDLE; in SEND or WAIT_DONE the message SHALL be completed first.
REQ-033 o_send_en SHALL be 0 in every state except SEND.
REQ-034 A message SHALL never be popped twice or transmitted without a pop.

Reset
REQ-035 i_reset_n=0 SHALL immediately force state=IDLE; o_send_data=0, o_send_en=0, o_src_r_en=0, o_src_sel=0, o_tx_ok=0, o_tx_fail=0, latch_data=0, retry count=0 and synchronizer flops=0.
REQ-036 Reset mid-transmission SHALL drop the message without any status pulse; the first PREPARE evaluation after release SHALL occur no earlier than 3 cycles after reset release.

Structure
REQ-037 A shared package can_tx_pkg SHALL hold the state enum, the MODE encodings and an ID-extract function.
REQ-038 Winner selection SHALL be a sub-module can_tx_prio_sel (combinational N_SRC-way compare).

Verification
REQ-039 Reset: assert i_reset_n=0 during SEND -> all outputs 0 and state=IDLE within the same cycle.
REQ-040 MODE 0, i_src_valid=4'b0110 -> o_src_sel=1, o_src_r_en=4'b0010 for one cycle, o_send_en=1 two cycles after PREPARE.
REQ-041 MODE 1, IDs 0x7FF/0x010/0x010/0x123, all valid -> o_src_sel=1 (tie resolved to the lower index).
REQ-042 MAX_RETRY=3 with three i_arb_lost pulses -> send_en re-asserts twice, one o_tx_fail pulse, exactly one pop.
REQ-043 i_tx_done and i_arb_lost in the same cycle -> o_tx_ok=1, o_tx_fail=0, next state PREPARE.
REQ-044 i_abort in WAIT_DONE -> o_tx_fail pulse, o_send_en=0, then the next valid source is popped.
